imm_gen: RTL and testbench

//   LX32 (RV32I) immediate generator in the decode stage. Extracts and sign-extends
//   the I/S/B/U/J immediate of a 32-bit instruction combinationally and reports the format.

---
 rtl/lx32_arch_pkg.sv | 53 +++++
 rtl/imm_gen.sv | 34 +++
 tb/tb_imm_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lx32_arch_pkg.sv
// LX32 architectural constants: opcodes, immediate format encoding and the
// pure decode/build helpers shared by the decode stage.
package lx32_arch_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Unknown, R-type and X/Z opcodes all fall to IMM_NONE through the default arm.
    function automatic imm_fmt_e decode_imm_fmt(input logic [31:0] instr);
        imm_fmt_e fmt;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = IMM_I;
            OP_STORE:                                      fmt = IMM_S;
            OP_BRANCH:                                     fmt = IMM_B;
            OP_LUI, OP_AUIPC:                              fmt = IMM_U;
            OP_JAL:                                        fmt = IMM_J;
            default:                                       fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic [31:0] build_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Decode-stage immediate generator: combinational immediate/format plus an
// enable-gated register copy handed to the execute stage.
module imm_gen
    import lx32_arch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        imm_fmt,
    output logic [XLEN-1:0] imm_q,
    output imm_fmt_e        imm_fmt_q
);

    always_comb begin
        imm_fmt = decode_imm_fmt(instr);
        imm     = build_imm(instr, imm_fmt);
    end

    // Decode -> execute boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_q     <= '0;
            imm_fmt_q <= IMM_NONE;
        end else if (en) begin
            imm_q     <= imm;
            imm_fmt_q <= imm_fmt;
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Directed bench for imm_gen: per-format immediate vectors and the
// enable/reset behaviour of the registered copy.
module tb_imm_gen;
    import lx32_arch_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] instr;
    logic [31:0] imm;
    imm_fmt_e    imm_fmt;
    logic [31:0] imm_q;
    imm_fmt_e    imm_fmt_q;

    int checks;
    int failures;

    imm_gen #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .instr     (instr),
        .imm       (imm),
        .imm_fmt   (imm_fmt),
        .imm_q     (imm_q),
        .imm_fmt_q (imm_fmt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic comb_vec(input string tag, input logic [31:0] word,
                            input logic [31:0] exp_imm, input imm_fmt_e exp_fmt);
        instr = word;
        #1;
        chk({tag, ".imm"}, imm, exp_imm);
        chk({tag, ".fmt"}, 32'(imm_fmt), 32'(exp_fmt));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        en       = 1'b0;
        instr    = 32'h0041_0093;

        // Reset state, and the combinational path working while reset is held
        #3;
        chk("rst.imm_q", imm_q, 32'h0);
        chk("rst.fmt_q", 32'(imm_fmt_q), 32'(IMM_NONE));
        chk("rst.comb_imm", imm, 32'h0000_0004);
        @(negedge clk);
        rst = 1'b0;

        // Spec vectors
        comb_vec("addi4",    32'h0041_0093, 32'h0000_0004, IMM_I);
        comb_vec("addi-16",  32'hff01_0113, 32'hffff_fff0, IMM_I);
        comb_vec("sw4",      32'h0011_2223, 32'h0000_0004, IMM_S);
        comb_vec("beq-8",    32'hfe00_0ce3, 32'hffff_fff8, IMM_B);
        comb_vec("lui",      32'h0000_2537, 32'h0000_2000, IMM_U);
        comb_vec("jal",      32'h3d00_00ef, 32'h0000_03d0, IMM_J);
        comb_vec("add",      32'h0020_8033, 32'h0000_0000, IMM_NONE);
        // Boundaries and remaining opcodes
        comb_vec("jalr_min", 32'h8000_0067, 32'hffff_f800, IMM_I);
        comb_vec("lw",       32'h0081_2083, 32'h0000_0008, IMM_I);
        comb_vec("fence",    32'h0ff0_000f, 32'h0000_00ff, IMM_I);
        comb_vec("ebreak",   32'h0010_0073, 32'h0000_0001, IMM_I);
        comb_vec("auipc",    32'hffff_f097, 32'hffff_f000, IMM_U);
        comb_vec("sw-4",     32'hfe11_2e23, 32'hffff_fffc, IMM_S);
        comb_vec("b_maxpos", 32'h7e00_0fe3, 32'h0000_0ffe, IMM_B);
        comb_vec("j_neg",    32'hffff_f06f, 32'hffff_fffe, IMM_J);
        comb_vec("unknown",  32'h0000_007f, 32'h0000_0000, IMM_NONE);

        // Capture with en=1
        @(negedge clk);
        instr = 32'hff01_0113;
        en    = 1'b1;
        @(posedge clk);
        #1;
        chk("cap.imm_q", imm_q, 32'hffff_fff0);
        chk("cap.fmt_q", 32'(imm_fmt_q), 32'(IMM_I));

        // Hold with en=0
        @(negedge clk);
        instr = 32'h0011_2223;
        en    = 1'b0;
        @(posedge clk);
        #1;
        chk("hold.imm_q", imm_q, 32'hffff_fff0);
        chk("hold.fmt_q", 32'(imm_fmt_q), 32'(IMM_I));

        // Capture the new instruction
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("cap2.imm_q", imm_q, 32'h0000_0004);
        chk("cap2.fmt_q", 32'(imm_fmt_q), 32'(IMM_S));

        // Asynchronous reset pulse between edges
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst.imm_q", imm_q, 32'h0);
        chk("arst.fmt_q", 32'(imm_fmt_q), 32'(IMM_NONE));
        chk("arst.comb_imm", imm, 32'h0000_0004);
        chk("arst.comb_fmt", 32'(imm_fmt), 32'(IMM_S));
        #1;
        rst = 1'b0;

        // Recapture after reset release
        instr = 32'h3d00_00ef;
        @(posedge clk);
        #1;
        chk("recap.imm_q", imm_q, 32'h0000_03d0);
        chk("recap.fmt_q", 32'(imm_fmt_q), 32'(IMM_J));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
